// File: rtl/proc_pkg.sv
// Shared processor definitions: fixed instruction encodings and the fetch-entry record.
package proc_pkg;
    localparam logic [31:0] NOP_IR  = 32'h00000013;
    localparam logic [31:0] HALT_IR = 32'h000f0033;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_t;
endpackage

// File: rtl/m_ifetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; DEPTH must be a power of two.
module m_ifetch_fifo
    import proc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_t                   din,
    output fetch_t                   dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    fetch_t         store [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) store[wr_ptr] <= din;
    end
endmodule

// File: rtl/m_ifetch.sv
// Instruction prefetch stage: sequential issue, return buffering, redirect flush and halt stop.
// Optional IFETCH_BYPASS_EN forwards a memory return straight to ID when the FIFO is empty.
module m_ifetch
    import proc_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_ce,
    output logic [ADDR_W-1:0] w_imem_addr,
    input  logic [31:0]       w_imem_rdata,
    input  logic              w_redirect,
    input  logic [31:0]       w_redirect_pc,
    input  logic              w_ir_rdy,
    output logic              w_ir_vld,
    output logic [31:0]       w_ir,
    output logic [31:0]       w_ir_pc,
    output logic              w_halted
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]  r_fpc;
    logic [31:0]  r_inflight_pc;
    logic         r_inflight;
    logic         r_halted;

    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    fetch_t        head;
    fetch_t        ret_entry;
    fetch_t        out_entry;
    logic [CW:0]   occupancy;
    logic          redirect_act;
    logic          halt_ret;
    logic          ret;
    logic          issue;
    logic          push;
    logic          pop;

    assign redirect_act = w_ce & w_redirect;
    assign ret          = w_ce & r_inflight & ~w_redirect;
    assign halt_ret     = r_inflight & (w_imem_rdata == HALT_IR);
    assign occupancy    = {1'b0, count} + {{CW{1'b0}}, r_inflight};
    // A returning halt word blocks issue in its own cycle so nothing past it is fetched.
    assign issue        = w_ce & ~w_redirect & ~r_halted & ~halt_ret
                        & (occupancy < (CW+1)'(DEPTH));
    assign ret_entry    = '{ir: w_imem_rdata, pc: r_inflight_pc};

    // ID handshake: a transfer happens on a clock-enabled edge where w_ir_vld and w_ir_rdy are both high;
    // w_ir/w_ir_pc hold while w_ir_vld=1 and w_ir_rdy=0, and w_ir_vld is low in a redirect cycle.
`ifdef IFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = empty & r_inflight & ~redirect_act;
    assign w_ir_vld  = (~empty | bypass) & ~redirect_act;
    assign out_entry = bypass ? ret_entry : head;
    assign push      = ret & ~(bypass & w_ir_rdy);
`else
    assign w_ir_vld  = ~empty & ~redirect_act;
    assign out_entry = head;
    assign push      = ret;
`endif

    assign pop         = w_ce & w_ir_vld & w_ir_rdy & ~empty;
    assign w_ir        = w_ir_vld ? out_entry.ir : NOP_IR;
    assign w_ir_pc     = w_ir_vld ? out_entry.pc : 32'h0;
    assign w_halted    = r_halted;
    assign w_imem_addr = r_fpc[ADDR_W+1:2];

    m_ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .flush (redirect_act),
        .push  (push),
        .pop   (pop),
        .din   (ret_entry),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fpc         <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_halted      <= 1'b0;
        end else if (w_ce) begin
            if (w_redirect) begin
                r_fpc      <= w_redirect_pc & ~32'h3;
                r_inflight <= 1'b0;
                r_halted   <= 1'b0;
            end else begin
                r_inflight <= issue;
                if (issue) begin
                    r_inflight_pc <= r_fpc;
                    r_fpc         <= r_fpc + 32'd4;
                end
                if (ret && halt_ret) r_halted <= 1'b1;
            end
        end
    end

    assert property (@(posedge w_clk) disable iff (!w_rst_n) !(full && r_inflight));
endmodule
